// File: rtl/sprite_row_fetch_if.sv
// Beam/sprite position inputs, sprite ROM port and pixel output of sprite_row_fetch.
// master is the sprite engine side, slave the timing/ROM/CLUT side; SPR_XFLIP_EN adds xflip.
interface sprite_row_fetch_if #(
  parameter int CORDW     = 16,
  parameter int ADDRW     = 6,
  parameter int SPR_DATAW = 4
);
  logic                    line;
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] sy;
  logic signed [CORDW-1:0] sprx;
  logic signed [CORDW-1:0] spry;
  logic [ADDRW-1:0]        rom_addr;
  logic [SPR_DATAW-1:0]    rom_data;
  logic [SPR_DATAW-1:0]    pix;
  logic                    drawing;
`ifdef SPR_XFLIP_EN
  logic                    xflip;
`endif

  modport master (
`ifdef SPR_XFLIP_EN
    input  xflip,
`endif
    input  line, sx, sy, sprx, spry, rom_data,
    output rom_addr, pix, drawing
  );

  modport slave (
`ifdef SPR_XFLIP_EN
    output xflip,
`endif
    output line, sx, sy, sprx, spry, rom_data,
    input  rom_addr, pix, drawing
  );
endinterface

// File: rtl/sprite_row_fetch.sv
// Per-line sprite row fetch into a buffer, streamed as scaled colour indices with 1-cycle output latency.
// No backpressure: the ROM has fixed 1-cycle latency and output follows the beam; SPR_XFLIP_EN adds xflip.
module sprite_row_fetch #(
  parameter int CORDW      = 16,
  parameter int H_RES      = 640,
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_SCALE  = 3,
  parameter int SPR_DATAW  = 4,
  parameter int ADDRW      = $clog2(SPR_WIDTH*SPR_HEIGHT)
) (
  input  logic clk,
  input  logic rst,
  sprite_row_fetch_if.master bus
);
  localparam int DRAWH = SPR_HEIGHT << SPR_SCALE;
  localparam int COLW  = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
  localparam int SUBW  = (SPR_SCALE > 0) ? SPR_SCALE : 1;
  localparam int ROWW  = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;
  localparam int CNTW  = $clog2(SPR_WIDTH + 2);
  localparam logic [SUBW-1:0] SUB_MAX = SUBW'((1 << SPR_SCALE) - 1);
  localparam logic [COLW-1:0] COL_MAX = COLW'(SPR_WIDTH - 1);
  localparam logic signed [CORDW-1:0] DRAWH_S = CORDW'(DRAWH);
  localparam logic signed [CORDW-1:0] HRES_S  = CORDW'(H_RES);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_POS, DRAW} state_t;

  state_t                  state;
  logic [SPR_DATAW-1:0]    row_buf [SPR_WIDTH];
  logic [ROWW-1:0]         row;
  logic [CNTW-1:0]         cnt;
  logic [COLW-1:0]         col;
  logic [SUBW-1:0]         sub;
  logic signed [CORDW-1:0] sprx_l;
`ifdef SPR_XFLIP_EN
  logic                    flip_l;
`endif

  logic signed [CORDW-1:0] dy;
  logic                    line_hit;
  logic [ROWW-1:0]         line_row;
  logic [ADDRW-1:0]        line_base;
  logic [ADDRW-1:0]        row_base;
  logic                    in_clip;
  logic                    emit;
  logic                    last_pix;
  logic [COLW-1:0]         cur_col, nxt_col, rd_col;
  logic [SUBW-1:0]         cur_sub, nxt_sub;

  always_comb begin
    dy        = bus.sy - bus.spry;
    line_hit  = !dy[CORDW-1] && (dy < DRAWH_S);
    line_row  = ROWW'(dy >>> SPR_SCALE);
    line_base = ADDRW'(line_row) * ADDRW'(SPR_WIDTH);
    row_base  = ADDRW'(row) * ADDRW'(SPR_WIDTH);
    in_clip   = !bus.sx[CORDW-1] && (bus.sx < HRES_S);
    // The match cycle in WAIT_POS already emits pixel 0, so it acts as DRAW with zeroed counters.
    emit      = (state == DRAW) || ((state == WAIT_POS) && (bus.sx == sprx_l));
    cur_col   = (state == DRAW) ? col : '0;
    cur_sub   = (state == DRAW) ? sub : '0;
    last_pix  = (cur_col == COL_MAX) && (cur_sub == SUB_MAX);
    if (cur_sub == SUB_MAX) begin
      nxt_sub = '0;
      nxt_col = cur_col + COLW'(1);
    end else begin
      nxt_sub = cur_sub + SUBW'(1);
      nxt_col = cur_col;
    end
`ifdef SPR_XFLIP_EN
    rd_col    = flip_l ? (COL_MAX - cur_col) : cur_col;
`else
    rd_col    = cur_col;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.pix      <= '0;
      bus.drawing  <= 1'b0;
      bus.rom_addr <= '0;
      row          <= '0;
      cnt          <= '0;
      col          <= '0;
      sub          <= '0;
      sprx_l       <= '0;
`ifdef SPR_XFLIP_EN
      flip_l       <= 1'b0;
`endif
    end else if (bus.line) begin
      bus.drawing <= 1'b0;
      sprx_l      <= bus.sprx;
`ifdef SPR_XFLIP_EN
      flip_l      <= bus.xflip;
`endif
      row         <= line_row;
      cnt         <= CNTW'(1);
      if (line_hit) begin
        state        <= LOAD;
        bus.rom_addr <= line_base;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        LOAD: begin
          bus.drawing <= 1'b0;
          // Data for the address issued two edges ago is on rom_data now.
          if (cnt >= CNTW'(2))
            row_buf[COLW'(cnt - CNTW'(2))] <= bus.rom_data;
          if (cnt < CNTW'(SPR_WIDTH))
            bus.rom_addr <= row_base + ADDRW'(cnt);
          if (cnt == CNTW'(SPR_WIDTH + 1))
            state <= WAIT_POS;
          cnt <= cnt + CNTW'(1);
        end
        WAIT_POS, DRAW: begin
          if (emit) begin
            bus.pix     <= row_buf[rd_col];
            bus.drawing <= in_clip;
            col         <= nxt_col;
            sub         <= nxt_sub;
            state       <= last_pix ? IDLE : DRAW;
          end else begin
            bus.drawing <= 1'b0;
          end
        end
        default: begin
          bus.drawing <= 1'b0;
        end
      endcase
    end
  end
endmodule
